pipe_ctrl_flow: RTL and testbench
=================================

Name: pipe_ctrl_flow

Overview:
- Parametrised successor to the plain valid/ready pipeline controller. Generates per-stage load enables for an external STAGE-deep datapath.
- Adds features the plain controller lacks:
  - synchronous flush
  - per-stage kill (bubble insertion)
  - global stall
  - in-flight credit limit (MAX_INFLIGHT)
  - occupancy reporting
- Sits beside every multi-cycle NPU datapath (MAC array, accumulators, post-processing). The datapath registers data only when the matching o_pipe_ctrl bit is high.

Parameters:
- STAGE, 4, number of pipeline register stages; legal range ≥1.
- MAX_INFLIGHT, STAGE, maximum number of valid tokens held at once; legal range 1..STAGE.
- CNT_W, $clog2(STAGE+1), width of the occupancy count; derived, do not override.

Ports:
- i_clk  in  1  clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_input_valid  in  1  upstream token valid.
- o_input_ready  out  1  upstream may transfer this cycle.
- o_output_valid  out  1  last stage holds a live token.
- i_output_ready  in  1  downstream accepts.
- i_stall  in  1  freeze all movement.
- i_flush  in  1  discard all tokens.
- i_kill  in  STAGE  bit i invalidates the token currently in stage i.
- o_pipe_ctrl  out  STAGE  bit i is the load enable of stage-i data register.
- o_stage_valid  out  STAGE  registered occupancy bit per stage.
- o_count  out  CNT_W  number of occupied stages (registered popcount of o_stage_valid).
- o_empty  out  1  o_count==0.

Behaviour:
- Reset: i_clk and i_reset only; reset is synchronous, active-high. While i_reset is high at a rising edge:
  - all occupancy bits clear, so o_stage_valid=0, o_count=0, o_empty=1, o_output_valid=0;
  - o_pipe_ctrl=0 and o_input_ready=0 while reset is asserted.
- Reset mid-operation drops all tokens without any output handshake.
- Effective occupancy: e[i] = occ[i] & ~i_kill[i] & ~i_flush.
- Valid chain: v[0] = i_input_valid, v[i+1] = e[i].
- Ready chain, all terms gated by ~i_stall & ~i_flush & ~i_reset:
  - r[STAGE] = i_output_ready;
  - r[i] = ~e[i] | r[i+1].
- Credit check:
  - fire_out = r[STAGE] & v[STAGE];
  - credit_ok = (popcount(e) < MAX_INFLIGHT) | fire_out.
- Handshake outputs:
  - o_input_ready = r[0] & credit_ok;
  - o_output_valid = e[STAGE-1] & ~i_stall.
- Stage transfers: rv[0] = o_input_ready & i_input_valid; rv[i] = r[i] & v[i] for i≥1.
- o_pipe_ctrl[i] = rv[i] for i=0..STAGE-1. Latency is STAGE cycles input-to-output with no back-pressure; throughput is 1 token/cycle when MAX_INFLIGHT=STAGE.
- Occupancy update: occ_next[i] = rv[i] | (e[i] & ~rv[i+1]).
  - A stage may pop and push in the same cycle.
  - A killed stage may accept a new token in the same cycle.
- Stall: all rv=0, tokens hold. Kill still clears the addressed bits; flush still clears everything.
- Flush: occ_next=0 for all stages; no o_pipe_ctrl bit, o_input_ready or o_output_valid asserted in the flush cycle. Flush has priority over stall, kill and handshakes.
- o_count/o_empty are registered from occ_next and are coherent with o_stage_valid every cycle.
- Combinational paths exist from i_output_ready, i_stall, i_flush and i_kill to o_input_ready and o_pipe_ctrl. This is intentional and matches the existing pipeline contract.
- Kill of an empty stage has no effect. Kill of the last stage while i_output_ready=1 suppresses the output transfer.
- Elaboration errors: STAGE<1, MAX_INFLIGHT<1 or MAX_INFLIGHT>STAGE.

Decomposition:
- pipe_ctrl_pkg holds:
  - function popcount(logic [N-1:0]) returning a CNT_W-sized count;
  - localparam helper for CNT_W;
  - parameter-check macro.
- Sub-module pipe_ctrl_flow_stage: one occupancy flop, with inputs rv_in, rv_out, kill, flush, reset and outputs occ, e. Instantiated STAGE times in a generate loop. The ready chain and credit logic stay in the top module.

Test Plan:
- Streaming: STAGE=4, MAX_INFLIGHT=4, valid and output_ready held 1 from cycle 0 → first o_output_valid at cycle 4, then one output per cycle, o_count steady at 4, o_pipe_ctrl=4'b1111.
- Back-pressure: pipeline full, i_output_ready=0 for 3 cycles → o_input_ready=0, o_pipe_ctrl=0, tokens hold. On release, one token pops per cycle and o_input_ready returns in the same cycle.
- Credit limit: STAGE=4, MAX_INFLIGHT=2, continuous valid, output_ready=0 → exactly 2 tokens accepted, o_count=2, o_input_ready=0. With output_ready=1, accept and retire occur in the same cycle and o_count stays 2.
- Kill: 4 tokens in flight, i_kill=4'b0100 for one cycle → o_count drops 4→3, exactly 3 outputs emerge, and a new input is accepted in the kill cycle if upstream is valid.
- Flush and stall: i_stall=1 with i_kill=4'b0001 → only stage 0 clears and the rest hold. Then i_flush=1 → next cycle o_count=0 and o_empty=1, with no o_output_valid in the flush cycle.
- Reset mid-stream: i_reset=1 for one edge while 3 tokens are in flight → o_stage_valid=0 and o_output_valid=0 next cycle. o_input_ready=0 while reset is high and returns to 1 the cycle after deassertion.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared helpers for the pipeline flow controller: count width, popcount and parameter checks.
// Count helpers are sized for the largest supported depth; callers truncate to their own width.
`ifndef PIPE_CTRL_CHECK_PARAMS
`define PIPE_CTRL_CHECK_PARAMS(S, M) \
  if ((S) < 1 || (S) > pipe_ctrl_pkg::PC_MAX_STAGE || (M) < 1 || (M) > (S)) begin : g_param_err \
    $error("pipe_ctrl_flow: illegal STAGE/MAX_INFLIGHT combination"); \
  end
`endif

package pipe_ctrl_pkg;

  localparam int PC_MAX_STAGE = 64;
  localparam int PC_CNT_MAX_W = $clog2(PC_MAX_STAGE + 1);

  function automatic int cnt_w(input int stage);
    return $clog2(stage + 1);
  endfunction

  function automatic logic [PC_CNT_MAX_W-1:0] popcount(input logic [PC_MAX_STAGE-1:0] vec);
    logic [PC_CNT_MAX_W-1:0] n;
    n = '0;
    for (int i = 0; i < PC_MAX_STAGE; i++) begin
      n = n + PC_CNT_MAX_W'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_ctrl_flow_if.sv
// Handshake, control and status bundle between a pipeline controller and its neighbours.
// The controller takes the slave view; the upstream/downstream environment drives the master view.
interface pipe_ctrl_flow_if
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGE = 4
);
  localparam int CNT_W = cnt_w(STAGE);

  logic             i_input_valid;
  logic             o_input_ready;
  logic             o_output_valid;
  logic             i_output_ready;
  logic             i_stall;
  logic             i_flush;
  logic [STAGE-1:0] i_kill;
  logic [STAGE-1:0] o_pipe_ctrl;
  logic [STAGE-1:0] o_stage_valid;
  logic [CNT_W-1:0] o_count;
  logic             o_empty;

  modport master (
    output i_input_valid, i_output_ready, i_stall, i_flush, i_kill,
    input  o_input_ready, o_output_valid, o_pipe_ctrl, o_stage_valid, o_count, o_empty
  );

  modport slave (
    input  i_input_valid, i_output_ready, i_stall, i_flush, i_kill,
    output o_input_ready, o_output_valid, o_pipe_ctrl, o_stage_valid, o_count, o_empty
  );

endinterface

// File: rtl/pipe_ctrl_flow_stage.sv
// One occupancy bit of the pipeline; e is the occupancy after this cycle's kill/flush.
// Holds its token unless the downstream stage loads it, and may refill in the same cycle.
module pipe_ctrl_flow_stage (
  input  logic i_clk,
  input  logic reset,
  input  logic rv_in,
  input  logic rv_out,
  input  logic kill,
  input  logic flush,
  output logic occ,
  output logic e
);

  logic occ_d;
  logic occ_q;

  always_comb begin
    e     = occ_q & ~kill & ~flush;
    occ_d = rv_in | (e & ~rv_out);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      occ_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;

endmodule

// File: rtl/pipe_ctrl_flow.sv
// Valid/ready controller generating load enables for a STAGE-deep datapath, with stall, flush, kill and credit limit.
// STAGE cycles input to output when unblocked; ready ripples back combinationally from i_output_ready.
module pipe_ctrl_flow
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGE        = 4,
  parameter int MAX_INFLIGHT = STAGE
) (
  input  logic            i_clk,
  input  logic            i_reset,
  pipe_ctrl_flow_if.slave bus
);

  localparam int CNT_W = cnt_w(STAGE);

  `PIPE_CTRL_CHECK_PARAMS(STAGE, MAX_INFLIGHT)

  logic [STAGE-1:0]        occ;
  logic [STAGE-1:0]        e;
  logic [STAGE:0]          v;
  logic [STAGE:0]          r;
  logic [STAGE:0]          rv;
  logic [STAGE-1:0]        occ_nxt;
  logic [PC_MAX_STAGE-1:0] e_ext;
  logic [PC_MAX_STAGE-1:0] nxt_ext;
  logic                    gate;
  logic                    fire_out;
  logic                    credit_ok;
  logic                    in_rdy;
  logic [CNT_W-1:0]        count_d;
  logic [CNT_W-1:0]        count_q;
  logic                    empty_d;
  logic                    empty_q;

  for (genvar g = 0; g < STAGE; g++) begin : g_stage
    pipe_ctrl_flow_stage u_stage (
      .i_clk  (i_clk),
      .reset  (i_reset),
      .rv_in  (rv[g]),
      .rv_out (rv[g+1]),
      .kill   (bus.i_kill[g]),
      .flush  (bus.i_flush),
      .occ    (occ[g]),
      .e      (e[g])
    );
  end

  always_comb begin
    gate = ~bus.i_stall & ~bus.i_flush & ~i_reset;

    v[0] = bus.i_input_valid;
    for (int i = 0; i < STAGE; i++) begin
      v[i+1] = e[i];
    end

    // Ready ripples from the output back towards the input.
    r[STAGE] = bus.i_output_ready & gate;
    for (int i = STAGE - 1; i >= 0; i--) begin
      r[i] = (~e[i] | r[i+1]) & gate;
    end

    e_ext            = '0;
    e_ext[STAGE-1:0] = e;
    fire_out  = r[STAGE] & v[STAGE];
    credit_ok = (popcount(e_ext) < PC_CNT_MAX_W'(MAX_INFLIGHT)) | fire_out;
    in_rdy    = r[0] & credit_ok;

    rv[0] = in_rdy & v[0];
    for (int i = 1; i <= STAGE; i++) begin
      rv[i] = r[i] & v[i];
    end

    for (int i = 0; i < STAGE; i++) begin
      occ_nxt[i] = rv[i] | (e[i] & ~rv[i+1]);
    end

    nxt_ext            = '0;
    nxt_ext[STAGE-1:0] = occ_nxt;
    count_d = CNT_W'(popcount(nxt_ext));
    empty_d = (occ_nxt == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  assign bus.o_input_ready  = in_rdy;
  assign bus.o_output_valid = e[STAGE-1] & ~bus.i_stall;
  assign bus.o_pipe_ctrl    = rv[STAGE-1:0];
  assign bus.o_stage_valid  = occ;
  assign bus.o_count        = count_q;
  assign bus.o_empty        = empty_q;

endmodule

// File: tb/tb_pipe_ctrl_flow.sv
// Drives two controllers (full credit and MAX_INFLIGHT=2) with directed and random traffic.
// Expected values come from a token-movement model of a 4-slot pipeline.
module tb_pipe_ctrl_flow;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       t_rst   = 1'b1;
  logic       t_ivld  = 1'b0;
  logic       t_ordy  = 1'b0;
  logic       t_stall = 1'b0;
  logic       t_flush = 1'b0;
  logic [3:0] t_kill  = 4'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [3:0] occ_m [2];
  logic [3:0] nx_m  [2];

  pipe_ctrl_flow_if #(.STAGE(4)) if_a ();
  pipe_ctrl_flow_if #(.STAGE(4)) if_b ();

  assign if_a.i_input_valid  = t_ivld;
  assign if_a.i_output_ready = t_ordy;
  assign if_a.i_stall        = t_stall;
  assign if_a.i_flush        = t_flush;
  assign if_a.i_kill         = t_kill;
  assign if_b.i_input_valid  = t_ivld;
  assign if_b.i_output_ready = t_ordy;
  assign if_b.i_stall        = t_stall;
  assign if_b.i_flush        = t_flush;
  assign if_b.i_kill         = t_kill;

  pipe_ctrl_flow #(.STAGE(4), .MAX_INFLIGHT(4)) dut_a (
    .i_clk   (clk),
    .i_reset (t_rst),
    .bus     (if_a.slave)
  );

  pipe_ctrl_flow #(.STAGE(4), .MAX_INFLIGHT(2)) dut_b (
    .i_clk   (clk),
    .i_reset (t_rst),
    .bus     (if_b.slave)
  );

  logic       ir_o  [2];
  logic       ov_o  [2];
  logic [3:0] ct_o  [2];
  logic [3:0] sv_o  [2];
  logic [2:0] cnt_o [2];
  logic       emp_o [2];

  assign ir_o[0]  = if_a.o_input_ready;
  assign ov_o[0]  = if_a.o_output_valid;
  assign ct_o[0]  = if_a.o_pipe_ctrl;
  assign sv_o[0]  = if_a.o_stage_valid;
  assign cnt_o[0] = if_a.o_count;
  assign emp_o[0] = if_a.o_empty;
  assign ir_o[1]  = if_b.o_input_ready;
  assign ov_o[1]  = if_b.o_output_valid;
  assign ct_o[1]  = if_b.o_pipe_ctrl;
  assign sv_o[1]  = if_b.o_stage_valid;
  assign cnt_o[1] = if_b.o_count;
  assign emp_o[1] = if_b.o_empty;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Tokens sit in slots 0..3; each cycle a token advances if the slot ahead is
  // empty or being vacated, and a new token enters slot 0 within the credit budget.
  task automatic model(input logic [3:0] occ, input int maxinf,
                       output logic ir, output logic ov,
                       output logic [3:0] ct, output logic [3:0] nx);
    logic [3:0] live;
    bit         space;
    int         held;
    ir = 1'b0;
    ct = 4'b0;
    nx = 4'b0;
    for (int i = 0; i < 4; i++) live[i] = occ[i] && !t_kill[i] && !t_flush;
    ov = live[3] && !t_stall;
    if (t_rst || t_flush) return;
    if (t_stall) begin
      nx = live;
      return;
    end
    space = t_ordy;
    for (int i = 3; i >= 0; i--) begin
      if (!live[i]) begin
        space = 1'b1;
      end else if (space) begin
        if (i < 3) begin
          ct[i+1] = 1'b1;
          nx[i+1] = 1'b1;
        end
      end else begin
        nx[i] = 1'b1;
      end
    end
    held = $countones(live);
    ir = space && ((held < maxinf) || (live[3] && t_ordy));
    if (ir && t_ivld) begin
      ct[0] = 1'b1;
      nx[0] = 1'b1;
    end
  endtask

  task automatic step(input logic rs, input logic iv, input logic od,
                      input logic st, input logic fl, input logic [3:0] kl);
    logic       ir;
    logic       ov;
    logic [3:0] ct;
    logic [3:0] nx;
    string      nm;
    t_rst = rs; t_ivld = iv; t_ordy = od; t_stall = st; t_flush = fl; t_kill = kl;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "a" : "b";
      model(occ_m[d], (d == 0) ? 4 : 2, ir, ov, ct, nx);
      if (!rs) begin
        chk({nm, ".in_rdy"}, 32'(ir_o[d]), 32'(ir));
        chk({nm, ".pipe_ctrl"}, 32'(ct_o[d]), 32'(ct));
      end else begin
        chk({nm, ".in_rdy_rst"}, 32'(ir_o[d]), 32'(0));
        chk({nm, ".pipe_ctrl_rst"}, 32'(ct_o[d]), 32'(0));
      end
      chk({nm, ".out_vld"}, 32'(ov_o[d]), 32'(ov));
      chk({nm, ".stage_valid"}, 32'(sv_o[d]), 32'(occ_m[d]));
      chk({nm, ".count"}, 32'(cnt_o[d]), 32'($countones(occ_m[d])));
      chk({nm, ".empty"}, 32'(emp_o[d]), 32'(occ_m[d] == 4'b0));
      nx_m[d] = nx;
    end
    @(posedge clk);
    #1;
    occ_m[0] = nx_m[0];
    occ_m[1] = nx_m[1];
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    occ_m[0] = 4'b0;
    occ_m[1] = 4'b0;

    step(1, 0, 0, 0, 0, 4'b0);

    // Streaming: first output appears four cycles after the first accept.
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 1, 0, 0, 4'b0);
      chk("stream_first_out", 32'(ov_o[0]), 32'(k >= 3));
      chk("stream_count", 32'(cnt_o[0]), 32'((k + 1 < 4) ? k + 1 : 4));
    end

    // Back-pressure on a full pipe, then release.
    repeat (3) step(0, 1, 0, 0, 0, 4'b0);
    repeat (4) step(0, 1, 1, 0, 0, 4'b0);

    // Credit limit on the MAX_INFLIGHT=2 instance.
    step(1, 0, 0, 0, 0, 4'b0);
    repeat (4) step(0, 1, 0, 0, 0, 4'b0);
    chk("credit_count", 32'(cnt_o[1]), 32'(2));
    chk("credit_in_rdy", 32'(ir_o[1]), 32'(0));
    repeat (6) step(0, 1, 1, 0, 0, 4'b0);

    // Kill a middle stage of a full pipe while upstream keeps offering.
    step(1, 0, 0, 0, 0, 4'b0);
    repeat (5) step(0, 1, 0, 0, 0, 4'b0);
    step(0, 1, 1, 0, 0, 4'b0100);
    repeat (6) step(0, 0, 1, 0, 0, 4'b0);

    // Stall with a kill, then flush.
    repeat (5) step(0, 1, 0, 0, 0, 4'b0);
    step(0, 0, 1, 1, 0, 4'b0001);
    step(0, 1, 1, 1, 1, 4'b0);
    step(0, 0, 1, 0, 0, 4'b0);
    chk("flush_empty", 32'(emp_o[0]), 32'(1));

    // Reset with three tokens in flight.
    repeat (3) step(0, 1, 0, 0, 0, 4'b0);
    step(1, 1, 1, 0, 0, 4'b0);
    repeat (3) step(0, 1, 1, 0, 0, 4'b0);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) < 3),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 32) == 0),
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
